// File: rtl/booth_r4_pp_accum.sv
// Radix-4 Booth partial-product accumulator: decodes one {enc,neg} digit per cycle (LSD first)
// and sums the shifted partial products into a signed 2*WIDTH product. Option: BOOTH_PP_APPROX_NEG_EN.
module booth_r4_pp_accum #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic                 dig_valid,
  output logic                 dig_ready,
  input  logic [2:0]           enc,
  input  logic                 neg,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 prod_valid,
  input  logic                 prod_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int NDIG = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_r, state_next_s;
  logic             dig_ready_r, busy_r, prod_valid_r;
  logic             dig_ready_next_s, busy_next_s, prod_valid_next_s;
  logic [WIDTH-1:0] mcand_r;
  logic [PW-1:0]    acc_r, prod_r, term_s, acc_sum_s;
  logic [CW-1:0]    cnt_r;
  logic             err_r, illegal_s, accept_s;

  function automatic logic is_illegal(input logic [2:0] e);
    return (e[1] == e[2]);
  endfunction

  // Negation happens after sign extension so that -(-2*mcand) does not overflow the WIDTH+1 pp.
  function automatic logic [PW-1:0] decode_pp(input logic [2:0] e, input logic n,
                                              input logic [WIDTH-1:0] m);
    logic [WIDTH:0] pp;
    logic [PW-1:0]  ext;
    logic           nz;
    pp = {(WIDTH+1){1'b0}};
    nz = 1'b0;
    if (is_illegal(e)) begin
      pp = {(WIDTH+1){1'b0}};
      nz = 1'b0;
    end else if (e[2]) begin
      pp = {m[WIDTH-1], m};
      nz = 1'b1;
    end else if (!e[0]) begin
      pp = {m, 1'b0};
      nz = 1'b1;
    end else begin
      pp = {(WIDTH+1){1'b0}};
      nz = 1'b0;
    end
    ext = {{(WIDTH-1){pp[WIDTH]}}, pp};
    if (n && nz) begin
`ifdef BOOTH_PP_APPROX_NEG_EN
      ext = ~ext;
`else
      ext = ~ext + {{(PW-1){1'b0}}, 1'b1};
`endif
    end else begin
      ext = ext;
    end
    return ext;
  endfunction

  assign accept_s  = dig_valid && dig_ready_r;
  assign illegal_s = is_illegal(enc);

  // Shifted partial product and running sum for the digit on the input
  always_comb begin
    term_s    = decode_pp(enc, neg, mcand_r) << {cnt_r, 1'b0};
    acc_sum_s = acc_r + term_s;
  end

  // State and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      dig_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      prod_valid_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      dig_ready_r  <= dig_ready_next_s;
      busy_r       <= busy_next_s;
      prod_valid_r <= prod_valid_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_next_s = S_ACCUM;
        else       state_next_s = S_IDLE;
      end
      S_ACCUM: begin
        if (accept_s && (cnt_r == LAST_CNT)) state_next_s = S_DONE;
        else                                 state_next_s = S_ACCUM;
      end
      S_DONE: begin
        if (prod_ready) state_next_s = S_IDLE;
        else            state_next_s = S_DONE;
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered above
  always_comb begin
    dig_ready_next_s  = 1'b0;
    busy_next_s       = 1'b0;
    prod_valid_next_s = 1'b0;
    case (state_next_s)
      S_IDLE: begin
        dig_ready_next_s  = 1'b0;
        busy_next_s       = 1'b0;
        prod_valid_next_s = 1'b0;
      end
      S_ACCUM: begin
        dig_ready_next_s  = 1'b1;
        busy_next_s       = 1'b1;
        prod_valid_next_s = 1'b0;
      end
      S_DONE: begin
        dig_ready_next_s  = 1'b0;
        busy_next_s       = 1'b1;
        prod_valid_next_s = 1'b1;
      end
      default: begin
        dig_ready_next_s  = 1'b0;
        busy_next_s       = 1'b0;
        prod_valid_next_s = 1'b0;
      end
    endcase
  end

  // Operand latch, accumulator, digit counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r <= {WIDTH{1'b0}};
      acc_r   <= {PW{1'b0}};
      prod_r  <= {PW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            mcand_r <= mcand;
            acc_r   <= {PW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            err_r   <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (accept_s) begin
            acc_r <= acc_sum_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            err_r <= err_r | illegal_s;
            if (cnt_r == LAST_CNT) prod_r <= acc_sum_s;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign dig_ready  = dig_ready_r;
  assign busy       = busy_r;
  assign prod_valid = prod_valid_r;
  assign prod       = prod_r;
  assign err        = err_r;

endmodule

// File: tb/tb_booth_r4_pp_accum.sv
// Directed-vector bench for booth_r4_pp_accum (WIDTH=8); expectations follow BOOTH_PP_APPROX_NEG_EN.
module tb_booth_r4_pp_accum;

  logic        clk = 1'b0;
  logic        rst, start, dig_valid, neg, prod_ready;
  logic [7:0]  mcand;
  logic [2:0]  enc;
  logic        dig_ready, prod_valid, busy, err;
  logic [15:0] prod;

  int n_vec = 0;
  int n_bad = 0;

`ifdef BOOTH_PP_APPROX_NEG_EN
  localparam logic [15:0] EXP1 = 16'hFFE7;
  localparam logic [15:0] EXP2 = 16'h3FC0;
`else
  localparam logic [15:0] EXP1 = 16'hFFEB;
  localparam logic [15:0] EXP2 = 16'h4000;
`endif

  // Digit packs: nibble i = {enc,neg} of digit i, digit 0 in the low nibble
  localparam logic [15:0] D_CASE1 = 16'h77B8;
  localparam logic [15:0] D_CASE2 = 16'h5666;
  localparam logic [15:0] D_ILLEG = 16'h7718;
  localparam logic [15:0] D_POS   = 16'h6684;

  booth_r4_pp_accum #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .enc(enc), .neg(neg),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] m);
    start = 1'b1;
    mcand = m;
    step();
    start = 1'b0;
    mcand = 8'h55;
  endtask

  task automatic send_digits(input logic [15:0] digs, input int first, input int last,
                             input int gap);
    for (int i = first; i <= last; i++) begin
      repeat (gap) step();
      for (int k = 0; k < 20 && !dig_ready; k++) step();
      check("dig_ready", 32'(dig_ready), 32'd1);
      enc       = digs[4*i+1 +: 3];
      neg       = digs[4*i];
      dig_valid = 1'b1;
      step();
      dig_valid = 1'b0;
      enc       = 3'b000;
      neg       = 1'b1;
    end
  endtask

  task automatic finish_op(input int hold, input logic st, input logic [15:0] exp_p,
                           input logic exp_e);
    check("latency_valid", 32'(prod_valid), 32'd1);
    check("done_busy", 32'(busy), 32'd1);
    check("done_dig_ready", 32'(dig_ready), 32'd0);
    check("prod", 32'(prod), 32'(exp_p));
    check("err", 32'(err), 32'(exp_e));
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", 32'(prod_valid), 32'd1);
      check("hold_prod", 32'(prod), 32'(exp_p));
      check("hold_err", 32'(err), 32'(exp_e));
    end
    prod_ready = 1'b1;
    start      = st;
    step();
    prod_ready = 1'b0;
    start      = 1'b0;
    check("idle_valid", 32'(prod_valid), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    step();
    check("stay_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dig_valid = 1'b0; neg = 1'b0; prod_ready = 1'b0;
    mcand = 8'h00; enc = 3'b011;
    repeat (3) step();
    check("rst_dig_ready", 32'(dig_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_prod_valid", 32'(prod_valid), 32'd0);
    check("rst_prod", 32'(prod), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    step();

    // 7 * -3, full rate; start held during release must be ignored
    start_op(8'd7);
    check("start_ready", 32'(dig_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    send_digits(D_CASE1, 0, 3, 0);
    finish_op(0, 1'b1, EXP1, 1'b0);

    // -128 * -128
    start_op(8'h80);
    send_digits(D_CASE2, 0, 3, 0);
    finish_op(0, 1'b0, EXP2, 1'b0);

    // Case 1 with digit gaps and consumer back-pressure
    start_op(8'd7);
    send_digits(D_CASE1, 0, 3, 2);
    finish_op(3, 1'b0, EXP1, 1'b0);

    // Illegal code in digit 1
    start_op(8'd7);
    send_digits(D_ILLEG, 0, 3, 0);
    finish_op(0, 1'b0, 16'h0007, 1'b1);

    // Next start clears err; 5 * 6
    start_op(8'd5);
    check("err_clear", 32'(err), 32'd0);
    send_digits(D_POS, 0, 3, 0);
    finish_op(0, 1'b0, 16'h001E, 1'b0);

    // Reset after two digits
    start_op(8'd7);
    send_digits(D_CASE1, 0, 1, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_ready", 32'(dig_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(prod_valid), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    step();
    start_op(8'd7);
    send_digits(D_CASE1, 0, 3, 0);
    finish_op(0, 1'b0, EXP1, 1'b0);

    // start with a new mcand during ACCUM is ignored
    start_op(8'd7);
    send_digits(D_CASE1, 0, 0, 0);
    start = 1'b1;
    mcand = 8'd3;
    send_digits(D_CASE1, 1, 2, 0);
    start = 1'b0;
    send_digits(D_CASE1, 3, 3, 0);
    finish_op(0, 1'b0, EXP1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/booth_r4_pp_accum.md
Name: booth_r4_pp_accum

Overview:
- Receiving end of the radix-4 Booth digit encoding used by the approximate multipliers.
- Consumes a stream of encoded Booth digits ({enc[2:0], neg}), least-significant digit first.
- Decodes each digit to {0, ±1, ±2}·multiplicand, shifts it, and accumulates it into a signed 2·WIDTH product.
- One digit per cycle; valid/ready on both the digit input and the product output.

Parameters:
- WIDTH, 8, signed operand width of multiplicand and multiplier; must be even and ≥4.
- NDIG, WIDTH/2, number of Booth digits per operation (derived, do not override).

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- mcand  in  WIDTH  signed multiplicand; latched on an accepted start.
- dig_valid  in  1  digit present.
- dig_ready  out  1  digit accepted when dig_valid && dig_ready.
- enc  in  3  encoded digit: enc[2]=|d|==1, enc[1]=~enc[2], enc[0]=(d==0 when enc[2]==0).
- neg  in  1  digit sign.
- prod  out  2*WIDTH  signed product.
- prod_valid  out  1  prod holds the final result.
- prod_ready  in  1  consumer takes the product.
- busy  out  1  high in ACCUM and DONE.
- err  out  1  sticky illegal-code flag for the current operation.

Behaviour:
- Reset (sync, active-high): state=IDLE, acc=0, cnt=0, prod=0, prod_valid=0, dig_ready=0, busy=0, err=0. Reset has priority over all other inputs. Reset mid-operation discards the partial result.
- Digit decode:
  - enc[1]==enc[2] is illegal: treat as a zero digit and set err.
  - enc[2]=1 → magnitude 1 (pp=mcand).
  - enc[2]=0 && enc[0]=0 → magnitude 2 (pp=mcand<<1).
  - enc[2]=0 && enc[0]=1 → zero.
  - pp is WIDTH+1 bits, signed.
  - neg=1 with nonzero magnitude → pp = -pp (two's complement).
  - A zero digit contributes 0 regardless of neg.
- Accumulate: acc += sign_extend(pp, 2*WIDTH) << (2*cnt), modulo 2^(2*WIDTH).
- FSM:
  - IDLE: dig_ready=0. On start=1: latch mcand, acc=0, cnt=0, err=0 → ACCUM.
  - ACCUM: dig_ready=1. Each accepted digit updates acc and cnt++. Accepting the digit with cnt==NDIG-1 → DONE. No dig_valid → hold state.
  - DONE: dig_ready=0, prod_valid=1, prod=acc. Stay until prod_ready=1 → IDLE, prod_valid deasserts next cycle. prod and err are stable while prod_valid=1 && !prod_ready.
- start outside IDLE is ignored. start in the same cycle as DONE→IDLE is ignored; a new start is accepted from the following IDLE cycle.
- Latency: 1 cycle for start, NDIG cycles at full digit rate, then prod_valid the cycle after the last digit. Minimum 1+NDIG cycles to prod_valid.
- Digit inputs are ignored outside ACCUM.

Optional Feature:
- Macro: BOOTH_PP_APPROX_NEG_EN.
- Defined: negative nonzero digits use one's complement, pp = ~pp, with no +1 correction. This is the approximate mode: error per negative digit is -2^(2*cnt).
- Undefined: exact two's-complement negation. Result equals mcand × multiplier exactly.
- Zero-digit handling and err are identical in both modes.

Test Plan:
- WIDTH=8, mcand=7, digits {enc,neg} = 100/0, 101/1, 011/1, 011/1 (multiplier -3) → prod=0xFFEB (-21), err=0. With BOOTH_PP_APPROX_NEG_EN → 0xFFE7 (-25).
- mcand=0x80 (-128), digits 011/0, 011/0, 011/0, 010/1 (multiplier -128) → prod=0x4000. Approx mode → 0x3FC0.
- Same op as case 1 with dig_valid gaps of 2 cycles between digits and prod_ready held low 3 cycles → prod=0xFFEB held stable with prod_valid=1 throughout; IDLE one cycle after prod_ready.
- Illegal digit enc=000 in position 1 within case 1 → treated as zero, prod=0x0007, err=1. Next start clears err to 0.
- rst asserted after 2 accepted digits → next cycle dig_ready=0, busy=0, prod_valid=0. Repeating case 1 then yields 0xFFEB.
- start pulsed while in ACCUM with mcand=3 → ignored; result still uses the original mcand=7.
